// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. Arithmetic and logic ops
// resolve in one cycle; shifts and rotates step one bit per cycle under a two-state FSM.
module alu_seq #(
   parameter int WIDTH         = 8,
   parameter bit CIN_FROM_FLAG = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             c_out,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             left_q, left_d;
   logic             rot_q, rot_d;
   logic             sar_q, sar_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             c_q, c_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;

   logic             accept;
   logic [SHW-1:0]   k;
   logic [WIDTH-1:0] bop;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] step_val;
   logic             step_bit;
   logic             load;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;

   always_comb begin
      k        = b[SHW-1:0];
      in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | out_ready);
      accept   = in_valid & in_ready;

      // SUB, INC and DEC all reuse the adder by choosing the second operand and carry-in.
      unique case (s[1:0])
         2'b00:   begin bop = b;        cin = CIN_FROM_FLAG ? c_q : c_in; end
         2'b01:   begin bop = ~b;       cin = 1'b1;                       end
         2'b10:   begin bop = '0;       cin = 1'b1;                       end
         default: begin bop = '1;       cin = 1'b0;                       end
      endcase
      sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};

      unique case (s[1:0])
         2'b00:   logic_res = a & b;
         2'b01:   logic_res = a | b;
         2'b10:   logic_res = a ^ b;
         default: logic_res = ~a;
      endcase

      if (left_q) begin
         step_bit = work_q[WIDTH-1];
         step_val = {work_q[WIDTH-2:0], rot_q & work_q[WIDTH-1]};
      end else begin
         step_bit = work_q[0];
         step_val = {(rot_q & work_q[0]) | (sar_q & work_q[WIDTH-1]), work_q[WIDTH-1:1]};
      end

      state_d     = state_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      rot_d       = rot_q;
      sar_d       = sar_q;
      out_valid_d = out_valid_q & ~out_ready;
      d_d         = d_q;
      c_d         = c_q;
      z_d         = z_q;
      n_d         = n_q;
      v_d         = v_q;
      load        = 1'b0;
      res         = a;
      res_c       = 1'b0;
      res_v       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (s[3:2])
                  2'b00: begin
                     load  = 1'b1;
                     res   = sum[WIDTH-1:0];
                     res_c = sum[WIDTH];
                     res_v = (a[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  2'b01: begin
                     load = 1'b1;
                     res  = logic_res;
                  end
                  default: begin
                     if (k == '0) begin
                        load = 1'b1;
                        res  = a;
                     end else begin
                        state_d = SHIFT;
                        work_d  = a;
                        cnt_d   = k;
                        left_d  = s[2];
                        rot_d   = (s[1:0] == 2'b01);
                        sar_d   = (s[1:0] == 2'b10) & ~s[2];
                     end
                  end
               endcase
            end
         end
         default: begin
            work_d = step_val;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               load    = 1'b1;
               res     = step_val;
               res_c   = step_bit;
               state_d = IDLE;
            end
         end
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         d_d         = res;
         c_d         = res_c;
         v_d         = res_v;
         z_d         = (res == '0);
         n_d         = res[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         left_q      <= 1'b0;
         rot_q       <= 1'b0;
         sar_q       <= 1'b0;
         out_valid_q <= 1'b0;
         d_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         rot_q       <= rot_d;
         sar_q       <= sar_d;
         out_valid_q <= out_valid_d;
         d_q         <= d_d;
         c_q         <= c_d;
         z_q         <= z_d;
         n_q         <= n_d;
         v_q         <= v_d;
      end
   end

   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign c_out     = c_q;
   assign z         = z_q;
   assign n         = n_q;
   assign v         = v_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed cases with known answers, then random
// operations against an arithmetic reference model, with random consumer back-pressure.
module tb_alu_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] s;
   logic       c_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] d;
   logic       c_out;
   logic       z;
   logic       n;
   logic       v;
   logic       busy;

   alu_seq #(.WIDTH(8), .CIN_FROM_FLAG(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .s(s), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .c_out(c_out), .z(z), .n(n), .v(v), .busy(busy)
   );

   typedef struct {
      logic [7:0] d;
      logic [3:0] f;   // {c, z, n, v}
      int         cyc;
      int         id;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   int  n_ops = 0;
   int  rdy_ctl = 1;   // 0 random, 1 always ready, 2 never ready

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected {d, c, z, n, v} from the operation rules, using plain integer arithmetic.
   function automatic logic [11:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                             input logic [3:0] rs, input logic rc);
      int ua, ub, sa, sb_, r, sr, k;
      logic [7:0] rd;
      logic rcy, rv;
      ua = {24'd0, ra};
      ub = {24'd0, rb};
      sa = {{24{ra[7]}}, ra};
      sb_ = {{24{rb[7]}}, rb};
      k = {29'd0, rb[2:0]};
      rcy = 1'b0;
      rv = 1'b0;
      rd = ra;
      r = 0;
      sr = 0;
      case (rs[3:2])
         2'b00: begin
            case (rs[1:0])
               2'b00: begin r = ua + ub + {31'd0, rc}; sr = sa + sb_ + {31'd0, rc}; rcy = (r > 255); end
               2'b01: begin r = ua - ub; sr = sa - sb_; rcy = (ua >= ub); end
               2'b10: begin r = ua + 1; sr = sa + 1; rcy = (ua == 255); end
               default: begin r = ua - 1; sr = sa - 1; rcy = (ua != 0); end
            endcase
            rd = r[7:0];
            rv = (sr > 127) || (sr < -128);
         end
         2'b01: begin
            case (rs[1:0])
               2'b00: rd = ra & rb;
               2'b01: rd = ra | rb;
               2'b10: rd = ra ^ rb;
               default: rd = ~ra;
            endcase
         end
         2'b10: begin
            if (k != 0) begin
               rcy = ra[k-1];
               case (rs[1:0])
                  2'b01: rd = 8'((ua >> k) | (ua << (8 - k)));
                  2'b10: rd = 8'(sa >>> k);
                  default: rd = 8'(ua >> k);
               endcase
            end
         end
         default: begin
            if (k != 0) begin
               rcy = ra[8-k];
               if (rs[1:0] == 2'b01) rd = 8'((ua << k) | (ua >> (8 - k)));
               else                  rd = 8'(ua << k);
            end
         end
      endcase
      return {rd, rcy, (rd == 8'h00), rd[7], rv};
   endfunction

   // Presents one operation, waits for acceptance, pushes its expected result.
   task automatic issue(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] ts,
                        input logic tc, input bit use_exp, input logic [11:0] dexp,
                        output int waited);
      sb_t e;
      logic [11:0] ex;
      int k;
      a = ta; b = tbv; s = ts; c_in = tc; in_valid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         if (waited >= 200) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
         waited++;
         @(posedge clk); #1;
      end
      k = ts[3] ? {29'd0, tbv[2:0]} : 0;
      ex = use_exp ? dexp : ref_model(ta, tbv, ts, tc);
      e.d = ex[11:4];
      e.f = ex[3:0];
      e.cyc = cyc + 1 + k;
      e.id = n_ops;
      n_ops++;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); s = 4'($urandom);
      for (int j = 0; j < k; j++) begin
         @(negedge clk);
         chk("busy_in_shift", 32'(busy), 32'd1);
         chk("in_ready_in_shift", 32'(in_ready), 32'd0);
         if (j == 0) begin a = 8'($urandom); s = 4'($urandom); end
      end
      if (k > 0) begin
         @(posedge clk); #1;
      end
   endtask

   // Consumer back-pressure driver.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_ctl)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever the consumer takes a result.
   initial begin
      bit prev_valid, prev_cons;
      logic [7:0] prev_d;
      logic [3:0] prev_f;
      int first_seen;
      sb_t e;
      prev_valid = 0; prev_cons = 0; prev_d = '0; prev_f = '0; first_seen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 0;
            prev_cons = 0;
            continue;
         end
         if (out_valid && (!prev_valid || prev_cons)) first_seen = cyc;
         if (prev_valid && !prev_cons) begin
            chk("held_valid", 32'(out_valid), 32'd1);
            chk("held_d", 32'(d), 32'(prev_d));
            chk("held_flags", 32'({c_out, z, n, v}), 32'(prev_f));
         end
         if (out_valid && !out_ready) chk("in_ready_when_stalled", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("op%0d_d", e.id), 32'(d), 32'(e.d));
               chk($sformatf("op%0d_flags_czn v", e.id), 32'({c_out, z, n, v}), 32'(e.f));
               chk($sformatf("op%0d_latency_cycle", e.id), 32'(first_seen), 32'(e.cyc));
            end
         end
         prev_valid = (out_valid === 1'b1);
         prev_cons = out_valid && out_ready;
         prev_d = d;
         prev_f = {c_out, z, n, v};
      end
   end

   initial begin
      int w;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; s = '0; c_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("in_ready_in_reset", 32'(in_ready), 32'd0);
      end
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_flags", 32'({c_out, z, n, v}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Directed cases: {d, c, z, n, v}
      issue(8'hF0, 8'h20, 4'b0000, 1'b1, 1, {8'h11, 4'b1000}, w);
      issue(8'h80, 8'h01, 4'b0001, 1'b0, 1, {8'h7F, 4'b1001}, w);
      issue(8'h81, 8'h03, 4'b1100, 1'b0, 1, {8'h08, 4'b0000}, w);
      issue(8'h01, 8'h01, 4'b1001, 1'b0, 1, {8'h80, 4'b1010}, w);
      issue(8'h90, 8'h02, 4'b1010, 1'b0, 1, {8'hE4, 4'b0010}, w);
      issue(8'hFF, 8'hFF, 4'b0110, 1'b0, 1, {8'h00, 4'b0100}, w);
      issue(8'h7F, 8'h00, 4'b0010, 1'b0, 1, {8'h80, 4'b0011}, w);
      issue(8'h00, 8'h00, 4'b0011, 1'b0, 1, {8'hFF, 4'b0010}, w);
      issue(8'hA5, 8'h08, 4'b1101, 1'b0, 1, {8'hA5, 4'b0010}, w);
      issue(8'h80, 8'h07, 4'b1000, 1'b0, 1, {8'h01, 4'b0000}, w);

      // Held result blocks acceptance; releasing out_ready admits the next op that cycle.
      @(posedge clk); #1;
      @(posedge clk); #1;
      rdy_ctl = 2; out_ready = 1'b0;
      issue(8'h3C, 8'h0F, 4'b0100, 1'b0, 0, 12'h000, w);
      a = 8'h10; b = 8'h22; s = 4'b0000; c_in = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("in_ready_blocked", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      rdy_ctl = 1; out_ready = 1'b1;
      issue(8'h10, 8'h22, 4'b0000, 1'b0, 1, {8'h32, 4'b0000}, w);
      chk("accept_same_cycle_as_consume", 32'(w), 32'd0);

      // Random operations under random back-pressure.
      rdy_ctl = 0;
      for (int i = 0; i < 300; i++) begin
         issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 0, 12'h000, w);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end

      rdy_ctl = 1; out_ready = 1'b1;
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      // Reset in the middle of a 7-step shift left.
      @(posedge clk); #1;
      a = 8'h01; b = 8'h07; s = 4'b1100; in_valid = 1'b1;
      @(negedge clk);
      chk("abort_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("no_result_after_abort", 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
